uart_rx: RTL and testbench

UART receiver that deserializes an asynchronous serial line into parallel bytes. It consumes the oversampling tick produced by `baudrate_generator` (16 ticks per bit period) and sits between the external RX pin and the UART interface/FIFO logic. It delivers one data word per frame with a single-cycle done strobe and a framing-error flag.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop deserializer with framing-error flag.
// Latency: 2-clk synchronizer + 1 clk + (8 + 16*NB_DATA + SB_TICK) ticks + 1 clk to o_rx_done.
// Backpressure: none; o_rx_done is a one-cycle strobe, o_data holds until the next frame.
module uart_rx #(
    parameter int NB_DATA     = 8,
    parameter int SB_TICK     = 16,
    parameter int NB_TICK_CNT = 5,
    parameter int NB_BIT_CNT  = 3
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [NB_TICK_CNT-1:0] TICK_MID  = NB_TICK_CNT'(7);
    localparam logic [NB_TICK_CNT-1:0] TICK_LAST = NB_TICK_CNT'(15);
    localparam logic [NB_TICK_CNT-1:0] TICK_STOP = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_BIT_CNT-1:0]  BIT_LAST  = NB_BIT_CNT'(NB_DATA - 1);

    logic [1:0]             sync_q;
    logic                   rx_s;

    state_t                 state, state_nx;
    logic [NB_TICK_CNT-1:0] s, s_nx;
    logic [NB_BIT_CNT-1:0]  n, n_nx;
    logic [NB_DATA-1:0]     shreg, shreg_nx;
    logic                   armed, armed_nx;
    logic [NB_DATA-1:0]     data_nx;
    logic                   done_nx;
    logic                   err_nx;

    // Both flops reset high so the line reads idle straight out of reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            shreg       <= '0;
            armed       <= 1'b0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nx;
            s           <= s_nx;
            n           <= n_nx;
            shreg       <= shreg_nx;
            armed       <= armed_nx;
            o_data      <= data_nx;
            o_rx_done   <= done_nx;
            o_frame_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_nx     = s;
        n_nx     = n;
        shreg_nx = shreg;
        armed_nx = armed;
        data_nx  = o_data;
        done_nx  = 1'b0;
        err_nx   = o_frame_err;

        case (state)
            IDLE: begin
                // A start is only trusted once the line has been seen idle,
                // which rejects the tail of a break or an interrupted frame.
                if (rx_s) begin
                    armed_nx = 1'b1;
                end
                if (armed && !rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                    armed_nx = 1'b0;
                end
            end

            START: begin
                if (i_tick) begin
                    if (s == TICK_MID) begin
                        s_nx = '0;
                        if (!rx_s) begin
                            state_nx = DATA;
                            n_nx     = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        s_nx = s + NB_TICK_CNT'(1);
                    end
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (s == TICK_LAST) begin
                        s_nx     = '0;
                        shreg_nx = {rx_s, shreg[NB_DATA-1:1]};
                        if (n == BIT_LAST) begin
                            state_nx = STOP;
                        end else begin
                            n_nx = n + NB_BIT_CNT'(1);
                        end
                    end else begin
                        s_nx = s + NB_TICK_CNT'(1);
                    end
                end
            end

            STOP: begin
                if (i_tick) begin
                    if (s == TICK_STOP) begin
                        s_nx     = '0;
                        state_nx = IDLE;
                        data_nx  = shreg;
                        err_nx   = ~rx_s;
                        done_nx  = 1'b1;
                    end else begin
                        s_nx = s + NB_TICK_CNT'(1);
                    end
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one 1-stop-bit instance and one SB_TICK=32 instance against a frame-level model.
module tb_uart_rx;

    localparam int TP  = 4;        // clocks per oversampling tick
    localparam int BIT = 16 * TP;  // clocks per bit period

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_tick;
    logic       rx16, rx32;
    logic [7:0] d16, d32;
    logic       done16, done32, err16, err32;

    uart_rx #(.NB_DATA(8), .SB_TICK(16), .NB_TICK_CNT(5), .NB_BIT_CNT(3)) dut16 (
        .clk(clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_rx(rx16),
        .o_data(d16), .o_rx_done(done16), .o_frame_err(err16)
    );

    uart_rx #(.NB_DATA(8), .SB_TICK(32), .NB_TICK_CNT(5), .NB_BIT_CNT(3)) dut32 (
        .clk(clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_rx(rx32),
        .o_data(d32), .o_rx_done(done32), .o_frame_err(err32)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick high during the cycle after every edge whose index is a multiple of TP,
    // so ticks are sampled on edges with index % TP == 1.
    initial begin
        i_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_tick = (cyc % TP == 0);
        end
    end

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       err;
        int         due;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] m_data[2];
    logic       m_err[2];
    int         done_cnt[2];
    int         last_done[2];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_dut(input int d, input logic done, input logic [7:0] data, input logic err);
        int idx;
        idx = -1;
        if (done) begin
            done_cnt[d]++;
            last_done[d] = cyc;
            foreach (expq[i]) if (idx < 0 && expq[i].dut == d) idx = i;
            if (idx < 0) begin
                chk($sformatf("unexpected_done%0d", d), 32'd1, 32'd0);
            end else begin
                chk($sformatf("done_data%0d", d), 32'(data), 32'(expq[idx].data));
                chk($sformatf("done_err%0d", d), 32'(err), 32'(expq[idx].err));
                chk($sformatf("done_cycle%0d", d), 32'(cyc), 32'(expq[idx].due));
                m_data[d] = expq[idx].data;
                m_err[d]  = expq[idx].err;
                expq.delete(idx);
            end
        end else begin
            chk($sformatf("hold_data%0d", d), 32'(data), 32'(m_data[d]));
            chk($sformatf("hold_err%0d", d), 32'(err), 32'(m_err[d]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_dut(0, done16, d16, err16);
            check_dut(1, done32, d32, err32);
            for (int i = expq.size() - 1; i >= 0; i--) begin
                if (expq[i].due < cyc) begin
                    chk($sformatf("missing_done%0d", expq[i].dut), 32'd0, 32'd1);
                    expq.delete(i);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel != 1) rx16 = v;
        if (sel != 0) rx32 = v;
    endtask

    task automatic align();
        while (cyc % TP != 1) begin
            @(posedge clk);
            #2;
        end
    endtask

    // sel: 0 = 1-stop instance, 1 = SB_TICK=32 instance, 2 = both.
    // rst_bit >= 0 pulses reset from inside that data bit until late in bit 7.
    task automatic send(input int sel, input logic [7:0] b, input logic stop_v,
                        input int rst_bit, output int a);
        align();
        a = cyc;
        if (rst_bit < 0) begin
            for (int d = 0; d < 2; d++) begin
                if (sel == 2 || sel == d) begin
                    // First counted tick lands on edge a+4; done follows the last stop tick.
                    expq.push_back('{dut: d, data: b, err: ~stop_v,
                                     due: a + 4 + (8 + 16 * 8 + (d == 1 ? 32 : 16) - 1) * TP});
                end
            end
        end
        set_line(sel, 1'b0);
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, b[i]);
            if (i == rst_bit) begin
                wait_cyc(20);
                i_rst_n = 1'b0;
                m_data[0] = 8'h00; m_err[0] = 1'b0;
                m_data[1] = 8'h00; m_err[1] = 1'b0;
                #1;
                chk("rst_mid_data", 32'(d16), 32'h00);
                chk("rst_mid_done", 32'(done16), 32'h0);
                chk("rst_mid_err", 32'(err16), 32'h0);
                wait_cyc(BIT - 20);
            end else if (rst_bit >= 0 && i == 7) begin
                wait_cyc(56);
                i_rst_n = 1'b1;
                wait_cyc(BIT - 56);
            end else begin
                wait_cyc(BIT);
            end
        end
        set_line(sel, stop_v);
        wait_cyc(BIT);
        if (!stop_v) begin
            wait_cyc(2 * BIT);
            set_line(sel, 1'b1);
        end
    endtask

    initial begin
        int a;
        i_rst_n = 1'b0;
        rx16 = 1'b1;
        rx32 = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_data[d] = 8'h00; m_err[d] = 1'b0;
            done_cnt[d] = 0; last_done[d] = 0;
        end
        wait_cyc(3);
        chk("reset_data", 32'(d16), 32'h00);
        chk("reset_done", 32'(done16), 32'h0);
        chk("reset_err", 32'(err16), 32'h0);
        i_rst_n = 1'b1;
        wait_cyc(10);

        // Nominal frame; 152 ticks of 4 clocks from the aligned falling edge.
        send(0, 8'hA5, 1'b1, -1, a);
        wait_cyc(100);
        chk("a5_latency", 32'(last_done[0] - a), 32'd608);
        chk("a5_data", 32'(d16), 32'hA5);
        chk("a5_err", 32'(err16), 32'h0);

        send(0, 8'h00, 1'b1, -1, a);
        send(0, 8'hFF, 1'b1, -1, a);
        wait_cyc(100);
        chk("b2b_count", 32'(done_cnt[0]), 32'd3);
        chk("b2b_data", 32'(d16), 32'hFF);

        // Short low pulse: rejected at the start-bit centre.
        align();
        set_line(0, 1'b0);
        wait_cyc(3 * TP);
        set_line(0, 1'b1);
        wait_cyc(800);
        chk("glitch_count", 32'(done_cnt[0]), 32'd3);
        chk("glitch_data", 32'(d16), 32'hFF);

        // Stop bit low plus two more low bit periods.
        send(0, 8'h3C, 1'b0, -1, a);
        wait_cyc(100);
        chk("ferr_count", 32'(done_cnt[0]), 32'd4);
        chk("ferr_data", 32'(d16), 32'h3C);
        chk("ferr_flag", 32'(err16), 32'h1);
        send(0, 8'h81, 1'b1, -1, a);
        wait_cyc(100);
        chk("after_ferr_data", 32'(d16), 32'h81);
        chk("after_ferr_flag", 32'(err16), 32'h0);

        // Reset during data bit 4 of 8'h5A, released in the (low) bit 7.
        send(0, 8'h5A, 1'b1, 4, a);
        wait_cyc(800);
        chk("rst_no_done", 32'(done_cnt[0]), 32'd5);
        send(0, 8'hC3, 1'b1, -1, a);
        wait_cyc(100);
        chk("after_rst_data", 32'(d16), 32'hC3);
        chk("after_rst_count", 32'(done_cnt[0]), 32'd6);

        // Same frame into both instances: 16 extra ticks of stop sampling.
        send(2, 8'h69, 1'b1, -1, a);
        wait_cyc(100);
        chk("sb32_delta", 32'(last_done[1] - last_done[0]), 32'(16 * TP));
        chk("sb32_data", 32'(d32), 32'h69);
        chk("sb16_data", 32'(d16), 32'h69);

        wait_cyc(800);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
